peripheral_inputsequencer: RTL and testbench
============================================

// Module: peripheral_inputsequencer
// PURPOSE
//  Upstream front-end of the operand capture stage. Synchronises and debounces
//  the raw ENTER key, emits a one-cycle enterpulse, and steps datainput_i through
//  the eight operand bytes (A then B), most-significant byte first.
//  After the 8th byte it raises operands_ready and fires a one-cycle start
//  toward the IEEE-754 multiplier.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000  stable cycles required before a key level is accepted (>=2)
//  BTN_ACTIVE_LOW   1      1: key_n raw level 0 = pressed; 0: level 1 = pressed
// PORTS
//  clk             in   1  system clock
//  reset           in   1  synchronous, active-high reset
//  key_n           in   1  raw asynchronous ENTER key
//  clear           in   1  synchronous restart of the sequence (level)
//  enterpulse      out  1  one-cycle strobe: store inputdata into byte datainput_i
//  datainput_i     out  4  byte index: 0-3 = A[31:24]..A[7:0]; 4-7 = B[31:24]..B[7:0]; 8 = done
//  operands_ready  out  1  high while all 8 bytes are captured (DONE state)
//  start           out  1  one-cycle strobe to the multiplier after the 8th byte
// BEHAVIOUR
//  Reset: enterpulse=0, datainput_i=0, operands_ready=0, start=0.
//   Debounced level = released; debounce counter = 0; FSM = COLLECT.
//  Sync: 2-FF synchroniser on key_n, then polarity-normalised to 'pressed'.
//  Debounce:
//   - counter increments while synced level != debounced level.
//   - When the counter reaches DEBOUNCE_CYCLES-1, debounced level <= synced level
//     and the counter clears.
//   - Any cycle with synced == debounced clears the counter (glitches rejected).
//  Press event: one cycle, on debounced released->pressed only. Holding never repeats.
//   Release generates nothing.
//  Latency: raw key held from edge at cycle t -> enterpulse high at cycle t+DEBOUNCE_CYCLES+3.
//  FSM (states COLLECT, DONE; index register idx[3:0]):
//   COLLECT, press, idx<7 : enterpulse=1 with datainput_i=idx; idx+1 next cycle.
//   COLLECT, press, idx=7 : enterpulse=1 with datainput_i=7; next cycle -> DONE,
//     datainput_i=8, operands_ready=1, start=1 for exactly that first DONE cycle.
//   DONE, press           : ignored (no enterpulse) unless the feature below is enabled.
//   any state, clear=1    : next cycle COLLECT, idx=0, operands_ready=0, start=0.
//     A press coincident with clear is discarded (enterpulse=0 that cycle).
//  Priority: reset > clear > press.
//  datainput_i is stable for the full cycle enterpulse is high; the consumer samples both
//   on the same edge.
//  clear does not disturb the debouncer; a key held through clear yields no new press
//   until released and re-pressed.
//  Reset mid-debounce discards the pending transition; a key held through reset is seen as
//   a press DEBOUNCE_CYCLES+3 cycles after reset deasserts.
// CONFIGURATION
//  INSEQ_AUTO_RESTART_EN
//   Defined: a press in DONE emits enterpulse with datainput_i=0, drops operands_ready,
//     and continues in COLLECT with idx=1 (new operand set without clear).
//   Undefined: presses in DONE are ignored; only clear or reset leaves DONE.
// TESTING (bench uses DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1)
//  1. Reset, key_n=1 for 20 cyc -> all outputs 0, datainput_i=0, no enterpulse.
//  2. key_n low at cycle t for 10 cyc, then high -> exactly one enterpulse at t+7 with
//     datainput_i=0; datainput_i=1 at t+8.
//  3. key_n low pulses of 2 cyc (shorter than debounce) -> no enterpulse, datainput_i unchanged.
//  4. 8 clean presses -> enterpulse with datainput_i 0..7 in order; then datainput_i=8,
//     operands_ready=1, start high exactly 1 cycle; 9th press -> no enterpulse (macro off)
//     / enterpulse with idx 0 and ready=0 (macro on).
//  5. clear asserted in the same cycle as the 3rd press -> enterpulse=0 that cycle;
//     next press yields datainput_i=0.
//  6. reset asserted with idx=5 while key held -> outputs 0 next cycle; press reported
//     DEBOUNCE_CYCLES+3 cycles after reset release with datainput_i=0.

Source files
------------

// File: rtl/peripheral_inputsequencer.sv
// ENTER-key front end: 2-FF synchroniser, debouncer, and an 8-byte operand index
// sequencer that raises operands_ready and a one-cycle start after the last byte.
// Optional: define INSEQ_AUTO_RESTART_EN so a press in DONE starts a new operand set.
module peripheral_inputsequencer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic       clear,
  output logic       enterpulse,
  output logic [3:0] datainput_i,
  output logic       operands_ready,
  output logic       start
);

  localparam int            CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Raw key level that means "released"; the synchroniser resets to it so a key held
  // through reset is seen as a fresh press afterwards.
  localparam logic          KEY_IDLE = BTN_ACTIVE_LOW;
  localparam logic [3:0]    IDX_LAST = 4'd7;
  localparam logic [3:0]    IDX_DONE = 4'd8;

  typedef enum logic {
    COLLECT,
    DONE
  } state_t;

  logic          key_meta;
  logic          key_sync;
  logic          key_pressed;
  logic          db_level;
  logic [CW-1:0] db_cnt;
  logic          press;
  state_t        state;
  logic [3:0]    idx;

  // NOTE: every register below uses non-blocking assignments so all flops update
  // from the same pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_meta <= KEY_IDLE;
      key_sync <= KEY_IDLE;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
    end
  end

  assign key_pressed = BTN_ACTIVE_LOW ? ~key_sync : key_sync;

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples;
  // press is a one-cycle flag raised on the released->pressed acceptance only.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_level <= 1'b0;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      press <= 1'b0;
      if (key_pressed != db_level) begin
        if (db_cnt == CNT_LAST) begin
          db_level <= key_pressed;
          db_cnt   <= '0;
          press    <= key_pressed;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // enterpulse doubles as the "byte consumed" marker: the index advances on the cycle
  // after the strobe, so datainput_i is stable for the whole strobe cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= COLLECT;
      idx            <= '0;
      enterpulse     <= 1'b0;
      operands_ready <= 1'b0;
      start          <= 1'b0;
    end else begin
      enterpulse <= 1'b0;
      start      <= 1'b0;
      if (clear) begin
        state          <= COLLECT;
        idx            <= '0;
        operands_ready <= 1'b0;
      end else if (enterpulse) begin
        if (idx == IDX_LAST) begin
          state          <= DONE;
          idx            <= IDX_DONE;
          operands_ready <= 1'b1;
          start          <= 1'b1;
        end else begin
          idx <= idx + 4'd1;
        end
      end else if (press) begin
        case (state)
          COLLECT: enterpulse <= 1'b1;
          DONE: begin
`ifdef INSEQ_AUTO_RESTART_EN
            state          <= COLLECT;
            idx            <= '0;
            enterpulse     <= 1'b1;
            operands_ready <= 1'b0;
`endif
          end
          default: state <= COLLECT;
        endcase
      end
    end
  end

  assign datainput_i = idx;

endmodule

// File: tb/tb_peripheral_inputsequencer.sv
// Self-checking bench for peripheral_inputsequencer (DEBOUNCE_CYCLES=4, active-low key)
// using a behavioural model of key acceptance and byte capture.
module tb_peripheral_inputsequencer;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_n;
  logic       clear;
  logic       enterpulse;
  logic [3:0] datainput_i;
  logic       operands_ready;
  logic       start;

  peripheral_inputsequencer #(
    .DEBOUNCE_CYCLES(D),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_n         (key_n),
    .clear         (clear),
    .enterpulse    (enterpulse),
    .datainput_i   (datainput_i),
    .operands_ready(operands_ready),
    .start         (start)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mism  = 0;

  // Model: pressed samples in flight through the synchroniser, accepted level,
  // length of the current disagreeing run, and the operand capture progress.
  bit         raw_q[$];
  bit         m_deb;
  int         m_run;
  bit         m_pend;
  bit         m_ep;
  int         m_count;
  bit         m_ready;
  bit         m_start;
  logic [3:0] m_di;

  int dut_ep_q[$];
  int dut_ep_cyc[$];
  int mdl_ep_q[$];
  int dut_start_n;
  int mdl_start_n;
  int dut_start_cyc;

  task automatic model_step();
    bit s;
    bit report;
    if (reset) begin
      raw_q   = {1'b0, 1'b0};
      m_deb   = 1'b0;
      m_run   = 0;
      m_pend  = 1'b0;
      m_ep    = 1'b0;
      m_count = 0;
      m_ready = 1'b0;
      m_start = 1'b0;
      m_di    = 4'd0;
    end else begin
      s = raw_q.pop_front();
      raw_q.push_back(!key_n);
      report = m_pend;
      m_pend = 1'b0;
      if (s != m_deb) begin
        m_run++;
        if (m_run == D) begin
          m_deb  = s;
          m_run  = 0;
          m_pend = s;
        end
      end else begin
        m_run = 0;
      end
      m_start = 1'b0;
      if (clear) begin
        m_count = 0;
        m_ep    = 1'b0;
        m_ready = 1'b0;
        m_di    = 4'd0;
      end else if (m_ep) begin
        m_ep = 1'b0;
        m_count++;
        if (m_count == 8) begin
          m_ready = 1'b1;
          m_start = 1'b1;
          m_di    = 4'd8;
        end else begin
          m_di = 4'(m_count);
        end
      end else if (report) begin
        if (m_count < 8) m_ep = 1'b1;
`ifdef INSEQ_AUTO_RESTART_EN
        else begin
          m_ep    = 1'b1;
          m_count = 0;
          m_ready = 1'b0;
          m_di    = 4'd0;
        end
`endif
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    if (enterpulse) begin
      dut_ep_q.push_back(int'(datainput_i));
      dut_ep_cyc.push_back(cyc);
    end
    if (m_ep) mdl_ep_q.push_back(int'(m_di));
    if (start) begin
      dut_start_n++;
      dut_start_cyc = cyc;
    end
    if (m_start) mdl_start_n++;
    if ({enterpulse, datainput_i, operands_ready, start} !== {m_ep, m_di, m_ready, m_start})
      mism++;
  endtask

  task automatic clear_logs();
    dut_ep_q.delete();
    dut_ep_cyc.delete();
    mdl_ep_q.delete();
    dut_start_n = 0;
    mdl_start_n = 0;
    dut_start_cyc = -1;
  endtask

  function automatic int q_diff(input int a[$], input int b[$]);
    int n = 0;
    if (a.size() != b.size()) return 1000;
    foreach (a[i]) if (a[i] != b[i]) n++;
    return n;
  endfunction

  task automatic press_key(input int hold, input int gap);
    key_n = 1'b0;
    repeat (hold) tick();
    key_n = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    int m0;
    reset = 1'b1;
    key_n = 1'b1;
    clear = 1'b0;
    repeat (3) tick();
    total++;
    if ({enterpulse, datainput_i, operands_ready, start} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {enterpulse, datainput_i, operands_ready, start});
    end
    reset = 1'b0;
    clear_logs();
    m0 = mism;
    repeat (20) tick();
    total++;
    if (dut_ep_q.size() !== 0) begin
      bad++;
      $display("FAIL reset_idle_pulses: got %0d want 0", dut_ep_q.size());
    end
    total++;
    if ({datainput_i, operands_ready, start} !== 6'b0) begin
      bad++;
      $display("FAIL reset_idle_outputs: got %b want 000000", {datainput_i, operands_ready, start});
    end
    total++;
    if (mism !== m0) begin
      bad++;
      $display("FAIL reset_model: got %0d mismatching cycles want 0", mism - m0);
    end
  endtask

  task automatic test_single_press();
    int m0;
    logic ep7, ep6;
    logic [3:0] di7, di8;
    clear_logs();
    m0 = mism;
    key_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 6) ep6 = enterpulse;
      if (k == 7) begin
        ep7 = enterpulse;
        di7 = datainput_i;
      end
      if (k == 8) di8 = datainput_i;
    end
    key_n = 1'b1;
    repeat (12) tick();
    total++;
    if (ep6 !== 1'b0 || ep7 !== 1'b1) begin
      bad++;
      $display("FAIL press_latency: got ep@6=%b ep@7=%b want 0 1", ep6, ep7);
    end
    total++;
    if (di7 !== 4'd0 || di8 !== 4'd1) begin
      bad++;
      $display("FAIL press_index: got %0d,%0d want 0,1", di7, di8);
    end
    total++;
    if (dut_ep_q.size() !== 1) begin
      bad++;
      $display("FAIL press_count: got %0d want 1", dut_ep_q.size());
    end
    total++;
    if (mism !== m0) begin
      bad++;
      $display("FAIL press_model: got %0d mismatching cycles want 0", mism - m0);
    end
  endtask

  task automatic test_glitch();
    int m0;
    clear_logs();
    m0 = mism;
    repeat (15) begin
      key_n = 1'b0;
      repeat ($urandom_range(1, D - 2)) tick();
      key_n = 1'b1;
      repeat ($urandom_range(1, 5)) tick();
    end
    repeat (8) tick();
    total++;
    if (dut_ep_q.size() !== 0) begin
      bad++;
      $display("FAIL glitch_pulses: got %0d want 0", dut_ep_q.size());
    end
    total++;
    if (datainput_i !== 4'd1) begin
      bad++;
      $display("FAIL glitch_index: got %0d want 1", datainput_i);
    end
    total++;
    if (mism !== m0) begin
      bad++;
      $display("FAIL glitch_model: got %0d mismatching cycles want 0", mism - m0);
    end
  endtask

  task automatic test_sequence();
    int m0;
    int order_err;
    do_clear();
    clear_logs();
    m0 = mism;
    for (int i = 0; i < 8; i++) press_key($urandom_range(D, D + 5), $urandom_range(D + 1, D + 6));
    order_err = 0;
    foreach (dut_ep_q[i]) if (dut_ep_q[i] != i) order_err++;
    total++;
    if (dut_ep_q.size() !== 8 || order_err !== 0) begin
      bad++;
      $display("FAIL seq_order: got %0d pulses %0d out of order want 8 0", dut_ep_q.size(), order_err);
    end
    total++;
    if (q_diff(dut_ep_q, mdl_ep_q) !== 0) begin
      bad++;
      $display("FAIL seq_vs_model: got %0d differences want 0", q_diff(dut_ep_q, mdl_ep_q));
    end
    total++;
    if (dut_start_n !== 1 || dut_ep_cyc.size() != 8 || dut_start_cyc !== dut_ep_cyc[7] + 1) begin
      bad++;
      $display("FAIL seq_start: got %0d starts at cycle %0d want 1 right after last pulse",
               dut_start_n, dut_start_cyc);
    end
    total++;
    if (datainput_i !== 4'd8 || operands_ready !== 1'b1 || start !== 1'b0) begin
      bad++;
      $display("FAIL seq_done: got idx=%0d ready=%b start=%b want 8 1 0",
               datainput_i, operands_ready, start);
    end
    clear_logs();
    press_key(D + 2, D + 6);
`ifdef INSEQ_AUTO_RESTART_EN
    total++;
    if (dut_ep_q.size() !== 1 || (dut_ep_q.size() == 1 && dut_ep_q[0] !== 0) ||
        operands_ready !== 1'b0 || datainput_i !== 4'd1) begin
      bad++;
      $display("FAIL seq_ninth: got %0d pulses ready=%b idx=%0d want 1 pulse at 0, ready 0, idx 1",
               dut_ep_q.size(), operands_ready, datainput_i);
    end
`else
    total++;
    if (dut_ep_q.size() !== 0 || operands_ready !== 1'b1 || datainput_i !== 4'd8) begin
      bad++;
      $display("FAIL seq_ninth: got %0d pulses ready=%b idx=%0d want 0 pulses, ready 1, idx 8",
               dut_ep_q.size(), operands_ready, datainput_i);
    end
`endif
    total++;
    if (mism !== m0) begin
      bad++;
      $display("FAIL seq_model: got %0d mismatching cycles want 0", mism - m0);
    end
  endtask

  task automatic test_clear_press();
    int m0;
    logic ep7;
    logic [3:0] di7;
    do_clear();
    clear_logs();
    m0 = mism;
    press_key(D + 2, D + 4);
    press_key(D + 2, D + 4);
    key_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      clear = (k == 7);
      tick();
      if (k == 7) begin
        ep7 = enterpulse;
        di7 = datainput_i;
      end
    end
    clear = 1'b0;
    key_n = 1'b1;
    repeat (D + 6) tick();
    press_key(D + 1, D + 6);
    total++;
    if (ep7 !== 1'b0 || di7 !== 4'd0) begin
      bad++;
      $display("FAIL clear_press: got ep=%b idx=%0d want 0 0", ep7, di7);
    end
    total++;
    if (dut_ep_q.size() !== 3 || (dut_ep_q.size() == 3 && dut_ep_q[2] !== 0)) begin
      bad++;
      $display("FAIL clear_next: got %0d pulses want 3 ending at index 0", dut_ep_q.size());
    end
    total++;
    if (mism !== m0) begin
      bad++;
      $display("FAIL clear_model: got %0d mismatching cycles want 0", mism - m0);
    end
  endtask

  task automatic test_reset_mid();
    int m0;
    int found;
    logic [3:0] di_f;
    do_clear();
    repeat (5) press_key($urandom_range(D, D + 3), $urandom_range(D + 1, D + 4));
    total++;
    if (datainput_i !== 4'd5) begin
      bad++;
      $display("FAIL rstmid_setup: got %0d want 5", datainput_i);
    end
    clear_logs();
    m0 = mism;
    key_n = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    total++;
    if ({enterpulse, datainput_i, operands_ready, start} !== 7'b0) begin
      bad++;
      $display("FAIL rstmid_outputs: got %b want 0000000",
               {enterpulse, datainput_i, operands_ready, start});
    end
    tick();
    reset = 1'b0;
    found = 0;
    di_f = 4'hf;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (enterpulse && found == 0) begin
        found = k;
        di_f = datainput_i;
      end
    end
    key_n = 1'b1;
    repeat (D + 6) tick();
    total++;
    if (found !== D + 3 || di_f !== 4'd0) begin
      bad++;
      $display("FAIL rstmid_press: got cycle %0d idx %0d want %0d 0", found, di_f, D + 3);
    end
    total++;
    if (mism !== m0) begin
      bad++;
      $display("FAIL rstmid_model: got %0d mismatching cycles want 0", mism - m0);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_sequence();
    test_clear_press();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
